// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
// Bounds are compared unsigned in WIDTH+1 bits; STEP_W must not exceed WIDTH.
module prog_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] M_SAT = 2'b01;
    localparam logic [1:0] M_ONE = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0] cnt_x, step_x, lo_x, hi_x;
    logic [WIDTH:0] sum_x, diff_x;
    logic           up_ev, dn_ev;
    logic           active, ev;

    assign cnt_x  = {1'b0, count_q};
    assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign lo_x   = {1'b0, lo};
    assign hi_x   = {1'b0, hi};
    assign sum_x  = cnt_x + step_x;
    assign diff_x = cnt_x - step_x;

    // Out-of-range count or lo > hi are compared literally.
    assign up_ev = (sum_x > hi_x);
    assign dn_ev = (cnt_x < step_x) || (diff_x < lo_x);

    assign active = en && (step != '0) &&
                    ((mode != M_ONE) || (state_q == S_RUN));
    assign ev     = !load && active && (up ? up_ev : dn_ev);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (load || (mode != M_ONE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_RUN;
                S_RUN:          if (ev)    state_d = S_DONE;
                default:                   state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == S_RUN);
    end

    always_comb begin
        count_d = count_q;
        tc_d    = ev;
        ovf_d   = ev ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        if (load) begin
            count_d = data_in;
        end else if (ev) begin
            case (mode)
                M_SAT, M_ONE: count_d = up ? hi : lo;
                default:      count_d = up ? lo : hi;
            endcase
        end else if (active) begin
            count_d = up ? sum_x[WIDTH-1:0] : diff_x[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter: directed scenarios, then
// randomized traffic checked against a cycle-level arithmetic model.
module tb_prog_updown_counter;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset, en, up, load, start, clr_ovf;
    logic [W-1:0]  data_in, lo, hi;
    logic [SW-1:0] step;
    logic [1:0]    mode;
    logic [W-1:0]  count;
    logic          tc, ovf, busy;

    always #5 clk = ~clk;

    prog_updown_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .data_in(data_in), .step(step), .lo(lo), .hi(hi),
        .mode(mode), .start(start), .clr_ovf(clr_ovf),
        .count(count), .tc(tc), .ovf(ovf), .busy(busy)
    );

    typedef struct {
        int   id;
        int   c;
        logic t;
        logic o;
        logic b;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_push = 0;

    // Reference state: count, last-cycle event, sticky flag, run armed.
    int m_cnt = 0;
    bit m_tc  = 0;
    bit m_ovf = 0;
    bit m_run = 0;

    task automatic model_step();
        int  c, s, lv, hv, nxt;
        bit  act, ev;
        c  = m_cnt;
        s  = int'(step);
        lv = int'(lo);
        hv = int'(hi);
        if (reset) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_run = 0;
        end else if (load) begin
            m_cnt = int'(data_in);
            m_tc  = 0;
            m_run = 0;
            if (clr_ovf) m_ovf = 0;
        end else begin
            act = en && (s != 0) && (mode != 2'b10 || m_run);
            ev  = 0;
            nxt = c;
            if (act) begin
                if (up) begin
                    if (c + s > hv) ev = 1;
                    else            nxt = c + s;
                end else begin
                    if (c < s || c - s < lv) ev = 1;
                    else                     nxt = c - s;
                end
            end
            if (ev) begin
                if (mode == 2'b01 || mode == 2'b10) nxt = up ? hv : lv;
                else                                nxt = up ? lv : hv;
            end
            if (mode != 2'b10) m_run = 0;
            else if (m_run)    m_run = !ev;
            else               m_run = start;
            m_cnt = nxt;
            m_tc  = ev;
            if (ev)           m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.id = n_push; e.c = m_cnt; e.t = m_tc; e.o = m_ovf; e.b = m_run;
        q.push_back(e);
        n_push++;
        #1;
    endtask

    // Hand-derived expectation; the model still advances to stay in step.
    task automatic tick_k(input int c, input bit t, input bit o, input bit b);
        exp_t e;
        @(posedge clk);
        model_step();
        e.id = n_push; e.c = c; e.t = t; e.o = o; e.b = b;
        q.push_back(e);
        n_push++;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (int'(count) != e.c || tc !== e.t ||
                    ovf !== e.o || busy !== e.b) begin
                    n_bad++;
                    $display("FAIL vec%0d: got count=%0d tc=%b ovf=%b busy=%b, want count=%0d tc=%b ovf=%b busy=%b",
                             e.id, count, tc, ovf, busy, e.c, e.t, e.o, e.b);
                end
            end
        end
    end

    task automatic quiet();
        reset = 0; en = 0; load = 0; start = 0; clr_ovf = 0;
    endtask

    initial begin : stim
        int mode_left, bnd_left;
        quiet();
        up = 1; data_in = 8'd77; step = 4'd1;
        lo = 8'd0; hi = 8'd255; mode = 2'b00;

        // reset beats load and enable
        reset = 1; load = 1; en = 1;
        tick_k(0, 0, 0, 0);

        // wrap up through 255
        quiet(); load = 1; data_in = 8'd254;
        tick_k(254, 0, 0, 0);
        load = 0; en = 1;
        tick_k(255, 0, 0, 0);
        tick_k(0, 1, 1, 0);
        tick_k(1, 0, 1, 0);

        // set wins over clear, then clear alone
        quiet(); load = 1; data_in = 8'd255;
        tick_k(255, 0, 1, 0);
        load = 0; en = 1; clr_ovf = 1;
        tick_k(0, 1, 1, 0);
        en = 0;
        tick_k(0, 0, 0, 0);

        // saturate down at lo re-triggers
        quiet(); mode = 2'b01; lo = 8'd10; hi = 8'd20; step = 4'd3; up = 0;
        load = 1; data_in = 8'd12;
        tick_k(12, 0, 0, 0);
        load = 0; en = 1;
        tick_k(10, 1, 1, 0);
        tick_k(10, 1, 1, 0);
        tick_k(10, 1, 1, 0);

        // step zero holds
        mode = 2'b00; step = 4'd0; up = 1;
        for (int i = 0; i < 5; i++) tick_k(10, 0, 1, 0);
        quiet(); clr_ovf = 1;
        tick_k(10, 0, 0, 0);

        // load with enable applies no step
        quiet(); lo = 8'd0; hi = 8'd255; step = 4'd3;
        load = 1; en = 1; data_in = 8'd100;
        tick_k(100, 0, 0, 0);
        load = 0;
        tick_k(103, 0, 0, 0);

        // one-shot run to hi
        quiet(); mode = 2'b10; hi = 8'd12; step = 4'd5; up = 1;
        load = 1; data_in = 8'd0;
        tick_k(0, 0, 0, 0);
        load = 0; en = 1; start = 1;
        tick_k(0, 0, 0, 1);
        start = 0;
        tick_k(5, 0, 0, 1);
        tick_k(10, 0, 0, 1);
        tick_k(12, 1, 1, 0);
        tick_k(12, 0, 1, 0);
        tick_k(12, 0, 1, 0);

        // reset aborts a run without tc
        quiet(); load = 1; data_in = 8'd0;
        tick_k(0, 0, 1, 0);
        load = 0; start = 1;
        tick_k(0, 0, 1, 1);
        start = 0; en = 1;
        tick_k(5, 0, 1, 1);
        reset = 1;
        tick_k(0, 0, 0, 0);
        reset = 0;
        tick_k(0, 0, 0, 0);

        // randomized traffic
        mode_left = 0;
        bnd_left  = 0;
        for (int i = 0; i < 800; i++) begin
            if (mode_left == 0) begin
                mode      = 2'($urandom_range(0, 5) % 4);
                if ($urandom_range(0, 2) == 0) mode = 2'b10;
                mode_left = $urandom_range(5, 40);
            end
            mode_left--;
            if (bnd_left == 0) begin
                lo       = 8'($urandom_range(0, 120));
                hi       = 8'($urandom_range(100, 255));
                if ($urandom_range(0, 7) == 0) lo = 8'($urandom_range(150, 255));
                bnd_left = $urandom_range(10, 60);
            end
            bnd_left--;
            reset   = ($urandom_range(0, 79) == 0);
            load    = ($urandom_range(0, 11) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) up = ~up;
            step    = 4'($urandom_range(0, 15));
            start   = ($urandom_range(0, 5) == 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            data_in = 8'($urandom_range(0, 255));
            tick();
        end

        quiet();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
